// File: rtl/riscv_irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: register map and FSM state type.
package riscv_defines;

    localparam logic [1:0] IRQ_ARB_MASK     = 2'd0;
    localparam logic [1:0] IRQ_ARB_PENDING  = 2'd1;
    localparam logic [1:0] IRQ_ARB_SECURE   = 2'd2;
    localparam logic [1:0] IRQ_ARB_PEND_SET = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_REQ   = 2'd1,
        IRQ_ACKED = 2'd2
    } irq_arb_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// 32-bit priority encoder: reports whether any bit is set and the highest set index.
module riscv_irq_prio_enc (
    input  logic [31:0] vec,
    output logic        valid,
    output logic [4:0]  idx
);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (vec[i]) idx = 5'(i);
        end
        valid = |vec;
    end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Interrupt arbiter: pending/mask/secure registers and a level request to the core
// carrying the highest-index enabled source.
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter int unsigned NUM_IRQ = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_event_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    output logic               irq_sec_o,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_ack_id_i
);

    // Lines at or above NUM_IRQ are tied off everywhere through this mask.
    localparam logic [31:0] VALID = 32'hFFFF_FFFF >> (32 - NUM_IRQ);

    logic [31:0]    pending, mask, secure;
    logic [31:0]    event_ext, ack_onehot, set_vec, clr_vec, active;
    logic           act_valid;
    logic [4:0]     top_id;
    irq_arb_state_e state;

    always_comb begin
        event_ext                = '0;
        event_ext[NUM_IRQ-1:0]   = irq_event_i;
        ack_onehot               = '0;
        if (irq_ack_i) ack_onehot[irq_ack_id_i] = 1'b1;
        set_vec = event_ext;
        clr_vec = ack_onehot;
        if (cfg_we_i && cfg_addr_i == IRQ_ARB_PEND_SET) set_vec = set_vec | cfg_wdata_i;
        if (cfg_we_i && cfg_addr_i == IRQ_ARB_PENDING)  clr_vec = clr_vec | cfg_wdata_i;
        set_vec = set_vec & VALID;
        clr_vec = clr_vec & VALID;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
            secure  <= '0;
        end else begin
            // Set is applied last so a same-cycle event survives an ack or W1C.
            pending <= (pending & ~clr_vec) | set_vec;
            if (cfg_we_i && cfg_addr_i == IRQ_ARB_MASK)   mask   <= cfg_wdata_i & VALID;
            if (cfg_we_i && cfg_addr_i == IRQ_ARB_SECURE) secure <= cfg_wdata_i & VALID;
        end
    end

    always_comb begin
        case (cfg_addr_i)
            IRQ_ARB_MASK:    cfg_rdata_o = mask;
            IRQ_ARB_PENDING: cfg_rdata_o = pending;
            IRQ_ARB_SECURE:  cfg_rdata_o = secure;
            default:         cfg_rdata_o = '0;
        endcase
    end

    assign active = pending & mask;

    riscv_irq_prio_enc u_prio_enc (
        .vec   (active),
        .valid (act_valid),
        .idx   (top_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IRQ_IDLE;
            irq_o     <= 1'b0;
            irq_id_o  <= '0;
            irq_sec_o <= 1'b0;
        end else begin
            case (state)
                IRQ_IDLE: begin
                    if (act_valid) begin
                        state     <= IRQ_REQ;
                        irq_o     <= 1'b1;
                        irq_id_o  <= top_id;
                        irq_sec_o <= secure[top_id];
                    end
                end
                IRQ_REQ: begin
                    if (irq_ack_i) begin
                        state <= IRQ_ACKED;
                        irq_o <= 1'b0;
                    end else if (!act_valid) begin
                        state <= IRQ_IDLE;
                        irq_o <= 1'b0;
                    end else begin
                        irq_id_o  <= top_id;
                        irq_sec_o <= secure[top_id];
                    end
                end
                IRQ_ACKED: begin
                    state <= IRQ_IDLE;
                    irq_o <= 1'b0;
                end
                default: begin
                    state <= IRQ_IDLE;
                    irq_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/riscv_irq_arbiter.md
# riscv_irq_arbiter

Interrupt source side of the core's interrupt-request interface. Collects up to 32 single-cycle interrupt events into a pending register, applies a software mask and per-line secure attribute, and presents the highest-priority enabled request to the core as a level request with a 5-bit id and secure bit. The core's acknowledge, carrying the taken id, clears that source's pending bit. Sits between the peripheral/event fabric and the RI5CY core irq inputs; configured through a small register port.

## Interface
- NUM_IRQ, 32, number of interrupt lines (1..32); ids NUM_IRQ..31 are tied off, never pending.
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- irq_event_i  in  NUM_IRQ  one-cycle event pulses; bit k sets pending[k].
- cfg_we_i  in  1  register write strobe.
- cfg_addr_i  in  2  register select: 0 MASK, 1 PENDING (W1C), 2 SECURE, 3 PEND_SET (W1S, reads 0).
- cfg_wdata_i  in  32  write data.
- cfg_rdata_o  out  32  combinational read data for cfg_addr_i.
- irq_o  out  1  level request to core.
- irq_id_o  out  5  id of the presented request.
- irq_sec_o  out  1  SECURE bit of the presented id.
- irq_ack_i  in  1  one-cycle acknowledge from core.
- irq_ack_id_i  in  5  id being acknowledged.

## Operation
- Registers: pending, mask, secure (each 32 bits, bits ≥ NUM_IRQ read 0, ignore writes). Reset: all 0.
- pending next = (pending & ~clr) | set; set = irq_event_i | (PEND_SET write data); clr = (PENDING W1C data) | (ack one-hot of irq_ack_id_i when irq_ack_i). Set wins over clear on the same bit in the same cycle: no event is lost.
- active = pending & mask. Priority: highest index wins (id 31 highest).
- FSM, states IDLE, REQ, ACKED:
  - IDLE: irq_o=0. If active≠0 → REQ, registering id = highest active index and sec = secure[id].
  - REQ: irq_o=1. Each cycle re-arbitrate: id/sec track current highest active. If active becomes 0 (masked or cleared) → IDLE, irq_o drops next cycle. If irq_ack_i → ACKED.
  - ACKED: irq_o=0 for exactly one cycle (lets cleared pending bit settle before the core samples again); then → IDLE.
- irq_ack_i in IDLE or ACKED: pending bit still cleared; state unchanged.
- Ack of an id that is not pending: no pending change; REQ still → ACKED.
- Ack id ≥ NUM_IRQ: ignored for clearing.
- irq_id_o/irq_sec_o hold last value in IDLE/ACKED; 0 after reset.

## Timing
- All outputs except cfg_rdata_o registered.
- Event pulse in cycle N → pending set at edge N+1 → irq_o=1 with id at edge N+2 (2-cycle latency, mask already 1).
- Ack in cycle M → pending cleared and irq_o=0 at edge M+1; earliest re-assert at edge M+3.
- Config writes take effect at the next edge; a mask write affects irq_o one cycle later.
- rst asserted in any cycle: next edge all registers 0, state IDLE, irq_o=0; events during rst are dropped.
- cfg_rdata_o reflects register state, not same-cycle writes.

## Structure
- Shared package (riscv_defines): register address constants IRQ_ARB_MASK/PENDING/SECURE/PEND_SET and state enum type.
- One sub-module natural: riscv_irq_prio_enc (32-bit vector → valid + 5-bit highest index), reusable.

## Test plan
- Reset, mask=0xFFFF_FFFF, pulse event bit 5 at cycle 10 → irq_o=1, id=5 at cycle 12; ack id 5 → irq_o=0 next cycle, PENDING reads 0.
- Events 3 and 17 same cycle, SECURE=0x0002_0000 → id=17, sec=1; ack 17 → after ACKED cycle, id=3, sec=0.
- Pending 9 with mask=0 → irq_o stays 0; write MASK bit 9 → irq_o=1, id=9 two edges after write.
- Event bit 4 and ack id 4 in same cycle while pending[4]=1 → pending[4] stays 1, irq_o re-asserts with id 4 after ACKED.
- In REQ with id 12, W1C PENDING bit 12 (only active) → irq_o drops, FSM IDLE, no ack needed.
- rst asserted mid-REQ with pending 0x81 → next cycle irq_o=0, id=0, all registers read 0.
